serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that time-shares one 1-bit full-adder cell across WIDTH-bit operands, LSB first.
- Accepts an operand pair through a valid/ready handshake.
- Sequences WIDTH add steps, one bit per cycle.
- Presents sum, carry-out and signed overflow through a valid/ready output handshake.
- Sits in front of the adder datapath as its sequencer. It trades area for WIDTH-cycle latency.

---
 rtl/adder_pkg.sv | 18 +
 rtl/serial_fa_cell.sv | 21 ++
 rtl/serial_adder_ctrl.sv | 115 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding,
// default operand width and the signed-overflow rule used by scoreboards.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Two's-complement overflow: operands share a sign and the sum's sign differs.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR,
// time-shared by the serial adder controller across all operand bits.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g;
  logic g2;

  assign p  = x ^ y;
  assign g  = x & y;
  assign s  = p ^ ci;
  assign g2 = p & ci;
  assign co = g | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: accepts an operand pair, adds one bit per cycle
// LSB first through a single full-adder cell, then holds the result until taken.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic [WIDTH-1:0]   res_nxt;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               s;
  logic               co;

  serial_fa_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign res_nxt = {s, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // carry ^ co at the MSB step is carry-in vs carry-out of the sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          carry  <= co;
          if (last) begin
            sum  <= res_nxt;
            cout <= co;
            ovf  <= carry ^ co;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a scoreboard queue holds the
// expected result of each accepted operand pair until the DUT presents it.
module tb_serial_adder_ctrl;
  import adder_pkg::*;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for in_ready, performs the input handshake and queues the expected result.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
    logic [WIDTH:0] full;
    exp_t e;
    int waited;
    a = ta;
    b = tb_;
    cin = tc;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    full = {1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tc};
    e.s = full[WIDTH-1:0];
    e.c = full[WIDTH];
    e.o = ovf_of(ta[WIDTH-1], tb_[WIDTH-1], full[WIDTH-1]);
    q.push_back(e);
    checkOutput("run_busy", busy, 1);
    checkOutput("run_in_ready", in_ready, 0);
  endtask

  // Waits for out_valid, compares against the scoreboard, optionally stalls, then accepts.
  task automatic collectResult(input int hold, input bit toggle, input bit check_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 4 * WIDTH) begin
      if (toggle) begin
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        in_valid = ~in_valid;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      checkOutput("result_timeout", 32'd0, 32'd1);
      if (q.size() > 0) void'(q.pop_front());
      return;
    end
    if (q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    if (check_lat) checkOutput("latency", lat, WIDTH);
    checkOutput("sum", sum, e.s);
    checkOutput("cout", cout, e.c);
    checkOutput("ovf", ovf, e.o);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = WIDTH'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_sum", sum, e.s);
      checkOutput("hold_cout", cout, e.c);
      checkOutput("hold_ovf", ovf, e.o);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("post_valid", out_valid, 0);
    checkOutput("post_in_ready", in_ready, 1);
    checkOutput("post_sum", sum, e.s);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum, 0);

    applyStimulus(8'h35, 8'h4A, 1'b0);
    collectResult(0, 1'b0, 1'b1);
    applyStimulus(8'hFF, 8'h01, 1'b0);
    collectResult(0, 1'b0, 1'b1);
    applyStimulus(8'h7F, 8'h00, 1'b1);
    collectResult(0, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b0);
    collectResult(0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    collectResult(0, 1'b0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(8'hC3, 8'h5A, 1'b1);
    collectResult(5, 1'b0, 1'b0);

    $display("[TB] input toggling during RUN");
    applyStimulus(8'h96, 8'h2B, 1'b1);
    collectResult(0, 1'b1, 1'b1);

    $display("[TB] reset mid-RUN");
    applyStimulus(8'h12, 8'h34, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_cout", cout, 0);
    checkOutput("midrst_ovf", ovf, 0);
    applyStimulus(8'h01, 8'h02, 1'b0);
    collectResult(0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      collectResult(i % 3, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
